load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the number of BUSY cycles without MemReady before the access is aborted.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemReadM  input  1  MEM-stage load request.
REQ-005 MemWriteM  input  1  MEM-stage store request.
REQ-006 Funct3M  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, right-aligned.
REQ-009 ReadDataM  output  32  extended load result towards the MEM/WB register.
REQ-010 StallM  output  1  freezes PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB.
REQ-011 MisalignedM  output  1  one-cycle pulse, misaligned access detected.
REQ-012 BusErrM  output  1  one-cycle pulse, memory timeout.
REQ-013 MemReq, MemWe  output  1 each  memory request and write strobe.
REQ-014 MemAddr  output  32  word-aligned address ({ALUResultM[31:2],2'b00}).
REQ-015 MemWData  output  32  lane-replicated store data.
REQ-016 MemBe  output  4  byte enables.
REQ-017 MemReady  input  1  memory completion; MemRData is valid when it is high.
REQ-018 MemRData  input  32  word read data.

Function
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE, no access (MemReadM=MemWriteM=0): StallM=0, MemReq=0; the FSM stays in IDLE.
REQ-021 IDLE, aligned access: StallM=1 combinationally; address, data, MemBe, MemWe and funct3 are registered; next state BUSY.
REQ-022 BUSY: MemReq=1 and all Mem* outputs held stable; StallM=1; the timeout counter increments each cycle.
REQ-023 BUSY with MemReady=1: on a load, the extended MemRData is captured into ReadDataM; next state DONE.
REQ-024 DONE: StallM=0 and ReadDataM holds the result; MemReq=0; the MEM-stage inputs are ignored; next state IDLE (unconditional).
REQ-025 Minimum latency with zero-wait memory: StallM is high for 2 cycles, and the result is valid in the 3rd cycle.
REQ-026 MemReadM=MemWriteM=1 at the same time: the access is treated as a store.
REQ-027 Misalignment rules: H/HU accesses require addr[0]=0; W accesses require addr[1:0]=00.
REQ-028 On misalignment: MemReq is not asserted, MisalignedM=1 for that cycle, StallM=0, ReadDataM=0, the FSM stays in IDLE, and no memory write occurs.
REQ-029 Store MemBe: B uses 0001<<addr[1:0]; H uses 0011<<addr[1:0]; W uses 1111.
REQ-030 Store MemWData: B = byte replicated ×4; H = halfword replicated ×2; W = unchanged.
REQ-031 Load: the selected lane is chosen by addr[1:0]; B/H are sign-extended, BU/HU zero-extended, and W is passed through.
REQ-032 Timeout: when the counter reaches TIMEOUT_CYCLES-1 in BUSY without MemReady, BusErrM=1 for one cycle, ReadDataM=0, and the next state is DONE.
REQ-033 MemReady while in IDLE or DONE is ignored.
REQ-034 Undefined Funct3M values are handled as W.

Reset
REQ-035 reset=1 at a clock edge forces state IDLE, counter 0, ReadDataM=0, and all Mem* outputs 0; StallM, MisalignedM and BusErrM are 0 afterwards.
REQ-036 Reset during BUSY abandons the transaction: MemReq is 0 in the next cycle, and a late MemReady is ignored.

Structure
REQ-037 Funct3 load/store encodings and the FSM state type are placed in the shared riscv package.
REQ-038 Lane select and sign/zero extension are implemented in one combinational sub-module, load_extend.

Verification
REQ-039 LW addr 0x100, MemReady immediately, MemRData=0xDEADBEEF -> StallM high 2 cycles, then ReadDataM=0xDEADBEEF.
REQ-040 SB addr 0x103, WriteDataM=0x000000A5 -> MemBe=1000, MemWData=0xA5A5A5A5, MemWe=1.
REQ-041 LB addr 0x102 and LBU addr 0x102, MemRData=0x00800000 -> ReadDataM=0xFFFFFF80 and 0x00000080 respectively.
REQ-042 LW addr 0x101 -> MisalignedM pulse, MemReq never asserted, StallM=0, ReadDataM=0.
REQ-043 LH addr 0x200 with MemReady held low, TIMEOUT_CYCLES=4 -> BusErrM pulse after 4 BUSY cycles, ReadDataM=0, FSM returns to IDLE.
REQ-044 SW with MemReady delayed 3 cycles, reset asserted in the 2nd BUSY cycle -> MemReq=0 next cycle, a MemReady pulse one cycle later causes no state change.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings, LSU state type and
// access-size helpers used by the load/store unit and its lane extender.
package riscv_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } access_size_e;

    // Any funct3 outside the five defined encodings behaves as a word access.
    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        access_size_e size;
        size = access_size(funct3);
        return ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane out of a memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: registers one access, holds the memory request
// until MemReady or timeout, and stalls the pipeline while the access is open.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignedM,
    output logic        BusErrM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    input  logic        MemReady,
    input  logic [31:0] MemRData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       offset_reg;
    logic [2:0]       funct3_reg;
    logic [31:0]      read_data_reg;
    logic             bus_err_reg;

    logic        access;
    logic        misaligned;
    logic [1:0]  offset;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_value;

    assign access     = MemReadM | MemWriteM;
    assign offset     = ALUResultM[1:0];
    assign misaligned = (state_reg == IDLE) && access && access_misaligned(Funct3M, offset);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        case (access_size(Funct3M))
            SZ_B: begin
                be_next    = 4'b0001 << offset;
                wdata_next = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                be_next    = 4'b0011 << offset;
                wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteDataM;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata  (MemRData),
        .offset (offset_reg),
        .funct3 (funct3_reg),
        .result (load_value)
    );

    // A misaligned access must read as zero in the very cycle it is flagged.
    assign ReadDataM   = misaligned ? 32'h0 : read_data_reg;
    assign StallM      = (state_reg == BUSY) || ((state_reg == IDLE) && access && !misaligned);
    assign MisalignedM = misaligned;
    assign BusErrM     = bus_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            offset_reg    <= '0;
            funct3_reg    <= '0;
            read_data_reg <= '0;
            bus_err_reg   <= 1'b0;
            MemReq        <= 1'b0;
            MemWe         <= 1'b0;
            MemAddr       <= '0;
            MemWData      <= '0;
            MemBe         <= '0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            read_data_reg <= '0;
                        end else begin
                            MemReq     <= 1'b1;
                            MemWe      <= MemWriteM;
                            MemAddr    <= {ALUResultM[31:2], 2'b00};
                            MemWData   <= wdata_next;
                            MemBe      <= be_next;
                            offset_reg <= offset;
                            funct3_reg <= Funct3M;
                            count_reg  <= '0;
                            state_reg  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (MemReady) begin
                        if (!MemWe) begin
                            read_data_reg <= load_value;
                        end
                        MemReq    <= 1'b0;
                        MemWe     <= 1'b0;
                        state_reg <= DONE;
                    end else if (count_reg == LAST_COUNT) begin
                        bus_err_reg   <= 1'b1;
                        read_data_reg <= '0;
                        MemReq        <= 1'b0;
                        MemWe         <= 1'b0;
                        state_reg     <= DONE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against an arithmetic model of sizes, lanes and extension.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignedM, BusErrM;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBe;
    logic        MemReady;
    logic [31:0] MemRData;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_read = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .Funct3M     (Funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignedM (MisalignedM),
        .BusErrM     (BusErrM),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemBe       (MemBe),
        .MemReady    (MemReady),
        .MemRData    (MemRData)
    );

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = size_bytes(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        int sz;
        sz = size_bytes(f3);
        if (sz == 1) return wdata[7:0] * 32'h01010101;
        if (sz == 2) return wdata[15:0] * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int     sz;
        longint v;
        sz = size_bytes(f3);
        if (sz == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) % (longint'(1) << (8 * sz));
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
        ALUResultM = 32'h0; WriteDataM = 32'h0; MemReady = 1'b0; MemRData = 32'h0;
    endtask

    // One full MEM-stage access: IDLE cycle, BUSY cycles, DONE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input string name);
        int          nbusy;
        bit          mis, tout;
        logic [31:0] exp_addr;
        mis      = (addr % size_bytes(f3)) != 0;
        tout     = waits >= T;
        exp_addr = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr;
        WriteDataM = wdata; MemReady = 1'b0; MemRData = $urandom;
        #1;
        if (mis) begin
            checks++;
            if ({StallM, MisalignedM, MemReq, MemWe, BusErrM, ReadDataM} !== {5'b01000, 32'h0}) begin
                failures++;
                $display("FAIL %s misaligned: stall/mis/req/we/buserr=%b%b%b%b%b read=%h expected 01000 read=00000000",
                         name, StallM, MisalignedM, MemReq, MemWe, BusErrM, ReadDataM);
            end
            exp_read = 32'h0;
            $display("txn %s rd=%0d wr=%0d f3=%0d addr=%h misaligned", name, rd, wr, f3, addr);
            return;
        end
        checks++;
        if ({StallM, MisalignedM, MemReq, BusErrM, ReadDataM} !== {4'b1000, exp_read}) begin
            failures++;
            $display("FAIL %s idle: stall/mis/req/buserr=%b%b%b%b read=%h expected 1000 read=%h",
                     name, StallM, MisalignedM, MemReq, BusErrM, ReadDataM, exp_read);
        end
        nbusy = tout ? T : waits + 1;
        for (int i = 0; i < nbusy; i++) begin
            @(negedge clk);
            MemReady = !tout && (i == waits);
            MemRData = MemReady ? rdata : $urandom;
            #1;
            checks++;
            if ({StallM, MemReq, MemWe, BusErrM, MemBe, MemAddr} !== {2'b11, wr, 1'b0, model_be(f3, addr), exp_addr}) begin
                failures++;
                $display("FAIL %s busy%0d: stall/req/we/buserr=%b%b%b%b be=%b addr=%h expected 11%b0 be=%b addr=%h",
                         name, i, StallM, MemReq, MemWe, BusErrM, MemBe, MemAddr, wr, model_be(f3, addr), exp_addr);
            end
            if (wr) begin
                checks++;
                if (MemWData !== model_wdata(f3, wdata)) begin
                    failures++;
                    $display("FAIL %s wdata: got %h expected %h", name, MemWData, model_wdata(f3, wdata));
                end
            end
        end
        if (tout) exp_read = 32'h0;
        else if (rd && !wr) exp_read = model_load(f3, addr, rdata);
        @(negedge clk);
        MemReady = 1'($urandom); MemRData = $urandom;
        MemReadM = 1'($urandom); MemWriteM = 1'($urandom); Funct3M = 3'($urandom);
        ALUResultM = $urandom; WriteDataM = $urandom;
        #1;
        checks++;
        if ({StallM, MisalignedM, MemReq, MemWe, BusErrM, ReadDataM} !== {4'b0000, tout, exp_read}) begin
            failures++;
            $display("FAIL %s done: stall/mis/req/we/buserr=%b%b%b%b%b read=%h expected 0000%b read=%h",
                     name, StallM, MisalignedM, MemReq, MemWe, BusErrM, ReadDataM, tout, exp_read);
        end
        $display("txn %s rd=%0d wr=%0d f3=%0d addr=%h wdata=%h rdata=%h waits=%0d timeout=%0d read=%h",
                 name, rd, wr, f3, addr, wdata, rdata, waits, tout, ReadDataM);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({StallM, MisalignedM, BusErrM, MemReq, MemWe, MemBe, MemAddr, MemWData, ReadDataM} !== '0) begin
            failures++;
            $display("FAIL reset: stall/mis/buserr/req/we=%b%b%b%b%b be=%b addr=%h wdata=%h read=%h expected all zero",
                     StallM, MisalignedM, BusErrM, MemReq, MemWe, MemBe, MemAddr, MemWData, ReadDataM);
        end
        exp_read = 32'h0;
        $display("txn reset released");
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_0x100");
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, "sb_0x103");
        run_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00800000, 1, "lb_0x102");
        run_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h00800000, 2, "lbu_0x102");
        run_access(1'b1, 1'b1, 3'b001, 32'h0FE, 32'h1234ABCD, 32'hFFFFFFFF, 0, "rdwr_is_sh");
        run_access(1'b1, 1'b0, 3'b111, 32'h204, 32'h0, 32'h87654321, 0, "undef_f3_lw");
    endtask

    task automatic test_misaligned();
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_0x101");
        run_access(1'b0, 1'b1, 3'b101, 32'h333, 32'hFFFF, 32'h0, 0, "shu_odd");
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({StallM, MisalignedM, MemReq, MemWe, ReadDataM} !== {4'b0000, 32'h0}) begin
            failures++;
            $display("FAIL misaligned_after: stall/mis/req/we=%b%b%b%b read=%h expected 0000 read=00000000",
                     StallM, MisalignedM, MemReq, MemWe, ReadDataM);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 32'h0, T + 3, "lh_timeout");
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({StallM, MemReq, BusErrM, ReadDataM} !== {3'b000, 32'h0}) begin
            failures++;
            $display("FAIL timeout_idle: stall/req/buserr=%b%b%b read=%h expected 000 read=00000000",
                     StallM, MemReq, BusErrM, ReadDataM);
        end
    endtask

    task automatic test_idle_ready();
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h5A5A0F0F, 0, "lw_before_idle_ready");
        @(negedge clk);
        clear_inputs();
        MemReady = 1'b1; MemRData = 32'h11112222;
        #1;
        checks++;
        if ({StallM, MemReq, MisalignedM, BusErrM} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ready: stall/req/mis/buserr=%b%b%b%b expected 0000", StallM, MemReq, MisalignedM, BusErrM);
        end
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        checks++;
        if ({StallM, MemReq, ReadDataM} !== {2'b00, exp_read}) begin
            failures++;
            $display("FAIL idle_ready_hold: stall/req=%b%b read=%h expected 00 read=%h", StallM, MemReq, ReadDataM, exp_read);
        end
    endtask

    task automatic test_reset_in_busy();
        @(negedge clk);
        MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
        WriteDataM = 32'hCAFEF00D; MemReady = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({StallM, MemReq, MemWe} !== 3'b111) begin
            failures++;
            $display("FAIL rst_busy1: stall/req/we=%b%b%b expected 111", StallM, MemReq, MemWe);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        exp_read = 32'h0;
        #1;
        checks++;
        if ({StallM, MemReq, MemWe, MemBe, MemAddr} !== '0) begin
            failures++;
            $display("FAIL rst_busy_after: stall/req/we=%b%b%b be=%b addr=%h expected all zero",
                     StallM, MemReq, MemWe, MemBe, MemAddr);
        end
        @(negedge clk);
        MemReady = 1'b1; MemRData = 32'h99999999;
        #1;
        checks++;
        if ({StallM, MemReq, BusErrM} !== 3'b000) begin
            failures++;
            $display("FAIL rst_late_ready: stall/req/buserr=%b%b%b expected 000", StallM, MemReq, BusErrM);
        end
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        checks++;
        if ({StallM, MemReq, BusErrM, ReadDataM} !== {3'b000, 32'h0}) begin
            failures++;
            $display("FAIL rst_late_after: stall/req/buserr=%b%b%b read=%h expected 000 read=00000000",
                     StallM, MemReq, BusErrM, ReadDataM);
        end
        $display("txn reset_in_busy sw addr=00000300");
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [31:0] addr;
        int          op, waits;
        for (int n = 0; n < 150; n++) begin
            op    = $urandom_range(0, 2);
            rd    = (op != 1);
            wr    = (op != 0);
            addr  = $urandom;
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            waits = ($urandom_range(0, 9) == 0) ? T + 1 : $urandom_range(0, 2);
            run_access(rd, wr, 3'($urandom_range(0, 7)), addr, $urandom, $urandom, waits, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 1'b1, 3'b001, 32'h402, 32'h0000BEEF, 32'h0, 0, "b2b_sh");
        run_access(1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 32'hBEEF0000, 0, "b2b_lh");
        run_access(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 32'hBEEF0000, 0, "b2b_lhu");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_idle_ready();
        test_reset_in_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
